// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-address stage: issues one word address per cycle, tracks in-flight PCs,
// applies execute-stage redirects and drains the pipe on halt.
module pc_fetch_unit #(
    parameter int                  PC_WIDTH     = 20,
    parameter int                  PIPE_DEPTH   = 3,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                halt_req,
    input  logic [8:0]          pcchange,
    input  logic [2:0]          pcjumpenable,
    input  logic [PC_WIDTH-1:0] pclocation,
    output logic [PC_WIDTH-1:0] programcounter,
    output logic                fetch_valid,
    output logic                flush,
    output logic [PC_WIDTH-1:0] previous_programcounter,
    output logic                halted,
    output logic                illegal_jump
);

    localparam int EXEC = PIPE_DEPTH - 1;

    typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_HALT} state_t;

    state_t                             state_q;
    logic [PC_WIDTH-1:0]                pc_q, prev_pc_q;
    logic                               fetch_valid_q, flush_q, halted_q, illegal_q;
    logic [PIPE_DEPTH-1:0]              hist_vld_q;
    logic [PIPE_DEPTH-1:0][PC_WIDTH-1:0] hist_pc_q;

    logic                exec_vld, redirect, illegal_hit;
    logic [PC_WIDTH-1:0] target_d, pc_d, prev_pc_d;

    // Entry in execute is ignored during the redirect bubble.
    assign exec_vld    = hist_vld_q[EXEC] && (state_q != S_REDIRECT);
    assign redirect    = exec_vld && (pcjumpenable == 3'd1 || pcjumpenable == 3'd2);
    assign illegal_hit = exec_vld && (pcjumpenable > 3'd2);
    assign target_d    = (pcjumpenable == 3'd2) ? pclocation
                       : hist_pc_q[EXEC] + {{(PC_WIDTH-9){pcchange[8]}}, pcchange};
    assign pc_d        = pc_q + {{(PC_WIDTH-1){1'b0}}, fetch_valid_q};
    assign prev_pc_d   = hist_pc_q[EXEC-1] + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_VECTOR;
            prev_pc_q     <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
            hist_vld_q    <= '0;
            hist_pc_q     <= '0;
        end else begin
            flush_q <= redirect;
            if (illegal_hit) illegal_q <= 1'b1;
            if (redirect) begin
                // The branching instruction is consumed and all younger ones squashed;
                // its pc field is kept so the link address stays stable.
                pc_q          <= target_d;
                fetch_valid_q <= 1'b0;
                hist_vld_q    <= '0;
                if (state_q == S_HALT) halted_q <= 1'b1;
                else                   state_q  <= S_REDIRECT;
            end else begin
                unique case (state_q)
                    S_RUN: if (!stall) begin
                        hist_vld_q <= {hist_vld_q[EXEC-1:0], fetch_valid_q};
                        hist_pc_q  <= {hist_pc_q[EXEC-1:0], pc_q};
                        prev_pc_q  <= prev_pc_d;
                        pc_q       <= pc_d;
                        if (halt_req) begin
                            state_q       <= S_HALT;
                            fetch_valid_q <= 1'b0;
                            halted_q      <= ~|{hist_vld_q[EXEC-1:0], fetch_valid_q};
                        end else begin
                            fetch_valid_q <= 1'b1;
                        end
                    end
                    S_REDIRECT: begin
                        state_q       <= S_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                    S_HALT: begin
                        if (!stall) begin
                            hist_vld_q <= {hist_vld_q[EXEC-1:0], 1'b0};
                            hist_pc_q  <= {hist_pc_q[EXEC-1:0], pc_q};
                            prev_pc_q  <= prev_pc_d;
                        end
                        if (!halt_req) begin
                            state_q       <= S_RUN;
                            fetch_valid_q <= 1'b1;
                            halted_q      <= 1'b0;
                        end else if (!stall) begin
                            halted_q <= ~|hist_vld_q[EXEC-1:0];
                        end
                    end
                    default: state_q <= S_RUN;
                endcase
            end
        end
    end

    assign programcounter          = pc_q;
    assign fetch_valid             = fetch_valid_q;
    assign flush                   = flush_q;
    assign previous_programcounter = prev_pc_q;
    assign halted                  = halted_q;
    assign illegal_jump            = illegal_q;

endmodule
